// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: scan state encoding, default frame
// geometry / blanking constants and a width helper for index ports.
package img_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VSYNC = 3'd1,
        ST_HSYNC = 3'd2,
        ST_DATA  = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_e;

    localparam int DEF_WIDTH       = 540;
    localparam int DEF_HEIGHT      = 360;
    localparam int DEF_VSYNC_DELAY = 100;
    localparam int DEF_HSYNC_DELAY = 160;

    // clog2 that never returns zero, so a degenerate dimension still gets a 1-bit port
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_scan_ctrl_if.sv
// Frame scan control/status bundle. master = frame requester / pixel writer,
// slave = the scan controller.
interface frame_scan_ctrl_if import img_pkg::*; #(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT
) ();
    localparam int RW = clog2_min1(HEIGHT);
    localparam int CW = clog2_min1(WIDTH);
    localparam int AW = clog2_min1(WIDTH * HEIGHT);

    logic          start;
    logic          abort;
    logic          out_ready;
    logic          VSYNC;
    logic          HSYNC;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [AW-1:0] pix_addr;
    logic          busy;
    logic          frame_done;

    modport master (
        output start, abort, out_ready,
        input  VSYNC, HSYNC, row, col, pix_addr, busy, frame_done
    );

    modport slave (
        input  start, abort, out_ready,
        output VSYNC, HSYNC, row, col, pix_addr, busy, frame_done
    );
endinterface

// File: rtl/sync_delay_cnt.sv
// Terminal-count counter: counts 0..term_i while run_i is high, wraps to 0
// on the terminal cycle so it is already cleared for the next phase.
module sync_delay_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             run_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tc_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // next count: clear wins, otherwise count and wrap at terminal
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (run_i)
            cnt_d = (cnt_q == term_i) ? '0 : cnt_q + 1'b1;
    end

    // count register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign tc_o = run_i && !clr_i && (cnt_q == term_i);
endmodule

// File: rtl/frame_scan_ctrl.sv
// Frame scan controller: VSYNC blanking, then per line HSYNC blanking
// followed by pixel-pair transfers gated by out_ready. pix_addr is kept
// as a running register (+2 per transfer) instead of WIDTH*row+col.
// Optional feature macro: FRAME_REPEAT_EN (DONE loops back to VSYNC).
module frame_scan_ctrl import img_pkg::*; #(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HEIGHT      = DEF_HEIGHT,
    parameter int VSYNC_DELAY = DEF_VSYNC_DELAY,
    parameter int HSYNC_DELAY = DEF_HSYNC_DELAY
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    frame_scan_ctrl_if.slave   bus
);
    localparam int RW    = clog2_min1(HEIGHT);
    localparam int CW    = clog2_min1(WIDTH);
    localparam int AW    = clog2_min1(WIDTH * HEIGHT);
    localparam int DMAX  = (VSYNC_DELAY > HSYNC_DELAY) ? VSYNC_DELAY : HSYNC_DELAY;
    localparam int CNT_W = clog2_min1(DMAX + 1);

    localparam logic [CW-1:0]    COL_LAST = CW'(WIDTH - 2);
    localparam logic [RW-1:0]    ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] VS_TERM  = CNT_W'(VSYNC_DELAY);
    localparam logic [CNT_W-1:0] HS_TERM  = CNT_W'(HSYNC_DELAY);

    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("frame_scan_ctrl: WIDTH must be even and >= 2");
    end
    if (HEIGHT < 1) begin : g_bad_height
        $error("frame_scan_ctrl: HEIGHT must be >= 1");
    end

    scan_state_e   state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          cnt_run, cnt_tc;

    // one shared counter times both blanking phases; it wraps on exit and
    // abort clears it, so each phase starts from zero
    assign cnt_run = (state_q == ST_VSYNC) || (state_q == ST_HSYNC);

    sync_delay_cnt #(.CNT_W(CNT_W)) u_dly (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .run_i   (cnt_run),
        .clr_i   (bus.abort),
        .term_i  ((state_q == ST_VSYNC) ? VS_TERM : HS_TERM),
        .tc_o    (cnt_tc)
    );

    // next state and scan indices
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        if (state_q != ST_IDLE && bus.abort) begin
            state_d = ST_IDLE;
            row_d   = '0;
            col_d   = '0;
            addr_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (bus.start && !bus.abort) state_d = ST_VSYNC;
                ST_VSYNC: if (cnt_tc) state_d = ST_HSYNC;
                ST_HSYNC: if (cnt_tc) state_d = ST_DATA;
                ST_DATA: begin
                    if (bus.out_ready) begin
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                // last pair: indices drop to zero on entry to DONE
                                state_d = ST_DONE;
                                row_d   = '0;
                                addr_d  = '0;
                            end else begin
                                state_d = ST_HSYNC;
                                row_d   = row_q + 1'b1;
                                addr_d  = addr_q + AW'(2);
                            end
                        end else begin
                            col_d  = col_q + CW'(2);
                            addr_d = addr_q + AW'(2);
                        end
                    end
                end
                ST_DONE: begin
                    row_d  = '0;
                    col_d  = '0;
                    addr_d = '0;
`ifdef FRAME_REPEAT_EN
                    state_d = ST_VSYNC;
`else
                    state_d = ST_IDLE;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // state and index registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.VSYNC      = (state_q == ST_VSYNC);
    assign bus.HSYNC      = (state_q == ST_DATA);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.frame_done = (state_q == ST_DONE);
    assign bus.row        = row_q;
    assign bus.col        = col_q;
    assign bus.pix_addr   = addr_q;
endmodule

// File: doc/frame_scan_ctrl.md
FRAME_SCAN_CTRL -- requirements
Module: frame_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 540: pixels per line; must be even and >= 2, elaboration error otherwise.
REQ-002 SHALL have parameter HEIGHT, default 360: lines per frame; must be >= 1.
REQ-003 SHALL have parameter VSYNC_DELAY, default 100: frame start-up blanking cycles minus one.
REQ-004 SHALL have parameter HSYNC_DELAY, default 160: per-line blanking cycles minus one.
REQ-005 SHALL have port HCLK, input, 1: clock, rising edge.
REQ-006 SHALL have port HRESETn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1: frame request, sampled in IDLE only.
REQ-008 SHALL have port abort, input, 1: synchronous frame cancel.
REQ-009 SHALL have port out_ready, input, 1: downstream writer accepts the current pixel pair.
REQ-010 SHALL have port VSYNC, output, 1: high while in VSYNC state.
REQ-011 SHALL have port HSYNC, output, 1: pixel-pair valid, high while in DATA state.
REQ-012 SHALL have port row, output, clog2(HEIGHT): current line index.
REQ-013 SHALL have port col, output, clog2(WIDTH): even column of the first pixel of the pair.
REQ-014 SHALL have port pix_addr, output, clog2(WIDTH*HEIGHT): WIDTH*row+col, registered, never multiplied at runtime.
REQ-015 SHALL have port busy, output, 1: state != IDLE.
REQ-016 SHALL have port frame_done, output, 1: one-cycle pulse after the last pair is accepted.

Function
REQ-017 SHALL implement states IDLE, VSYNC, HSYNC, DATA, DONE.
REQ-018 IDLE: start=1 -> VSYNC next cycle; otherwise stay.
REQ-019 VSYNC: counter runs 0..VSYNC_DELAY; at VSYNC_DELAY -> HSYNC, giving VSYNC_DELAY+1 cycles.
REQ-020 HSYNC: counter runs 0..HSYNC_DELAY; at HSYNC_DELAY -> DATA. Both counters SHALL clear on state exit.
REQ-021 DATA: a transfer SHALL occur on cycles with HSYNC=1 and out_ready=1. Each transfer SHALL advance col by 2 and pix_addr by 2.
REQ-022 DATA with out_ready=0: row, col and pix_addr SHALL hold stable (backpressure).
REQ-023 Transfer at col=WIDTH-2 with row<HEIGHT-1: col<=0, row<=row+1, -> HSYNC; pix_addr continues contiguously.
REQ-024 Transfer at col=WIDTH-2 with row=HEIGHT-1: -> DONE.
REQ-025 DONE: lasts one cycle with frame_done=1; row, col and pix_addr SHALL clear to 0; -> IDLE.
REQ-026 start outside IDLE SHALL be ignored, with no queuing.
REQ-027 abort=1 in any non-IDLE state: -> IDLE next cycle, counters and indices cleared, no frame_done.
REQ-028 abort and start both high in IDLE: abort SHALL win and the block stays IDLE.
REQ-029 Each frame SHALL deliver exactly WIDTH*HEIGHT/2 transfers, in order, with pix_addr 0,2,...,WIDTH*HEIGHT-2.

Reset
REQ-030 On HRESETn low: state=IDLE, all counters, row, col and pix_addr = 0, VSYNC=HSYNC=busy=frame_done=0.
REQ-031 Reset mid-frame SHALL abandon the frame immediately. After release, no activity SHALL occur until a new start.

Configuration
REQ-032 With FRAME_REPEAT_EN defined: DONE -> VSYNC instead of IDLE, so frames run back-to-back; frame_done still pulses each frame; abort returns to IDLE.
REQ-033 Without FRAME_REPEAT_EN: DONE -> IDLE, and one start yields exactly one frame.

Structure
REQ-034 SHALL place the state enum and the default WIDTH, HEIGHT, VSYNC_DELAY and HSYNC_DELAY constants in shared package img_pkg for use by the reader and writer.
REQ-035 SHALL instantiate one sub-module sync_delay_cnt (terminal-count counter with run/clear), used for the VSYNC and HSYNC timing.

Verification
All scenarios use WIDTH=4, HEIGHT=2, VSYNC_DELAY=2, HSYNC_DELAY=3.
REQ-036 start pulse, out_ready=1 -> VSYNC high 3 cycles, HSYNC low 4 cycles, then 2 valid pairs at pix_addr 0,2; then HSYNC low 4 cycles, then 2 pairs at 4,6; frame_done 1 cycle later; busy low.
REQ-037 out_ready low for 5 cycles mid-line at pix_addr=2 -> pix_addr/row/col frozen at 2/0/2; resumes with 4 total transfers, no skip or duplicate.
REQ-038 abort during DATA at pix_addr=4 -> IDLE next cycle, frame_done never asserted, outputs zero.
REQ-039 start re-pulsed during HSYNC, then start and abort together in IDLE -> both ignored, exactly one frame observed.
REQ-040 HRESETn low mid-VSYNC, then released -> all outputs 0 and IDLE until next start. With FRAME_REPEAT_EN: 3 frames run back-to-back with 3 frame_done pulses and VSYNC re-entered directly after each DONE.
